iter_div_responder: RTL and testbench
=====================================

Name: iter_div_responder

Overview:
- Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W variants.
- Responder side of the execute stage's divide handshake: div_valid/div_ready in, out_valid with quotient/remainder out.
- Holds one operation at a time and supports flush.
- Results follow RISC-V semantics, including divide-by-zero and signed overflow.

Parameters:
- XLEN, 64, operand/result width; the W-variant width is XLEN/2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- div_valid  in  1  request; operands are captured on div_valid & div_ready
- flush  in  1  abort the current operation
- div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
- divw  in  1  1 = 32-bit W variant
- div_op1  in  XLEN  dividend
- div_op2  in  XLEN  divisor
- div_ready  out  1  idle and able to accept
- out_valid  out  1  one-cycle result strobe
- quotient  out  XLEN  quotient
- remainder  out  XLEN  remainder

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE; out_valid=0; quotient=0; remainder=0.
  - div_ready=1 from the first cycle after reset.
  - Reset mid-operation abandons the operation; no out_valid is produced.
- States:
  - IDLE: div_ready=1. On div_valid & ~flush, capture operands and go to DONE if special, else BUSY.
  - BUSY: div_ready=0. Each cycle: shift the partial remainder left, bringing in the next dividend bit; trial-subtract |divisor|; set the quotient bit when the result is non-negative. Decrement the counter; when it reaches 0, go to DONE.
  - DONE: out_valid=1 for exactly this cycle, then IDLE.
- Latency, taking the acceptance cycle as 0:
  - Normal ops: BUSY in cycles 1..N, out_valid in cycle N+1. N=64 for XLEN ops and 32 for W ops, so out_valid is at cycle 65 or 33.
  - Special cases: out_valid in cycle 1.
- Operand preparation:
  - divw=1: use op[31:0], sign-extended if div_signed, else zero-extended.
  - Signed ops: iterate on absolute values.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved at acceptance:
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend == most-negative of the active width, divisor == -1): quotient = dividend; remainder = 0.
  - For W ops, the zero and overflow checks use the 32-bit view of the operands.
- W results: bits [31:0] are sign-extended to XLEN. This applies to DIVUW/REMUW as well.
- quotient/remainder:
  - Registered; updated only on entry to DONE.
  - Held stable until the next DONE, so the consumer may sample on out_valid or any time after.
- flush:
  - In any state, flush=1 forces IDLE at the next edge; out_valid=0 that cycle and the pending result is dropped.
  - flush together with div_valid in IDLE: flush wins, nothing is accepted.
  - flush in the DONE cycle: out_valid is still 1 in that cycle, since the result already exists; the state then goes to IDLE.
- div_valid while busy: ignored, because div_ready=0. The requester must hold it or re-issue.
- Back-to-back: the earliest next acceptance is the IDLE cycle following DONE.
- Operands are not required to stay stable after acceptance.

Decomposition:
- Shared package holds:
  - XLEN and the W width (32).
  - State encoding: IDLE/BUSY/DONE, 2 bits.
  - Iteration-count constants (64, 32).
  - Most-negative constants for both widths.
- One natural sub-module, div_operand_prep (combinational). It handles:
  - width select and extension;
  - absolute value;
  - zero/overflow detection;
  - result sign flags.
- The FSM, iteration datapath and final sign fix stay in the top module.

Test Plan:
- Unsigned 64-bit: op1=100, op2=7, signed=0, divw=0 -> out_valid exactly at cycle 65, quotient=14, remainder=2; div_ready=0 in cycles 1..65.
- Signed: op1=-7, op2=2 -> quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1).
- Specials, each with out_valid at cycle 1:
  - op2=0, op1=0x1234 -> quotient=all ones, remainder=0x1234.
  - Signed op1=0x8000_0000_0000_0000, op2=-1 -> quotient=0x8000_0000_0000_0000, remainder=0.
- W variant: divw=1, signed=0, op1=0xDEAD_BEEF_FFFF_FFFF, op2=1 -> out_valid at cycle 33, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0.
- Signed W overflow: op1=0x0000_0000_8000_0000, op2=0xFFFF_FFFF -> quotient=0xFFFF_FFFF_8000_0000.
- Flush: flush at BUSY cycle 10 -> no out_valid, div_ready=1 next cycle. A following 100/7 then returns 14/2 correctly.
- Reset in BUSY: same outcome, and quotient/remainder read 0 after reset.
- flush+div_valid in the same IDLE cycle -> no acceptance, div_ready stays 1.

Source files
------------

// File: rtl/iter_div_responder_pkg.sv
// iter_div_responder_pkg: shared widths, iteration counts, extreme values and FSM encoding for the divider
package iter_div_responder_pkg;
    localparam int DIV_XLEN = 64;
    localparam int DIV_WLEN = 32;
    localparam int CNT_W = 7;
    localparam logic [CNT_W-1:0] ITER_X = 7'd64;
    localparam logic [CNT_W-1:0] ITER_W = 7'd32;
    localparam logic [DIV_XLEN-1:0] MIN_X = {1'b1, {(DIV_XLEN-1){1'b0}}};
    localparam logic [DIV_WLEN-1:0] MIN_W = {1'b1, {(DIV_WLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/iter_div_responder_prep.sv
// div_operand_prep: width select, extension, magnitudes, special-case detection and result sign flags
module div_operand_prep
    import iter_div_responder_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    output logic [XLEN-1:0] a_ext,
    output logic [XLEN-1:0] a_abs,
    output logic [XLEN-1:0] b_abs,
    output logic            div_zero,
    output logic            ovf,
    output logic            q_neg,
    output logic            r_neg
);
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    always_comb begin
        a_ext = divw ? {{(XLEN-DIV_WLEN){div_signed & div_op1[DIV_WLEN-1]}}, div_op1[DIV_WLEN-1:0]} : div_op1;
        b_ext = divw ? {{(XLEN-DIV_WLEN){div_signed & div_op2[DIV_WLEN-1]}}, div_op2[DIV_WLEN-1:0]} : div_op2;
        a_neg = div_signed & a_ext[XLEN-1];
        b_neg = div_signed & b_ext[XLEN-1];
        a_abs = a_neg ? -a_ext : a_ext;
        b_abs = b_neg ? -b_ext : b_ext;
        div_zero = b_ext == '0;
        ovf = div_signed & (divw ? (a_ext[DIV_WLEN-1:0] == MIN_W && &b_ext[DIV_WLEN-1:0])
                                 : (a_ext == MIN_X && &b_ext));
        q_neg = a_neg ^ b_neg;
        r_neg = a_neg;
    end
endmodule

// File: rtl/iter_div_responder.sv
// iter_div_responder: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants
module iter_div_responder
    import iter_div_responder_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            flush,
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dvd;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dsr;
    logic [XLEN-1:0]  a_ext;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic [XLEN-1:0]  nxt_dvd;
    logic [XLEN-1:0]  nxt_rem;
    logic [XLEN-1:0]  fix_q;
    logic [XLEN-1:0]  fix_r;
    logic [XLEN-1:0]  spec_q;
    logic [XLEN-1:0]  spec_r;
    logic [XLEN:0]    shifted;
    logic             ge;
    logic             div_zero;
    logic             ovf;
    logic             q_neg;
    logic             r_neg;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             w_r;

    function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
        return w ? {{(XLEN-DIV_WLEN){x[DIV_WLEN-1]}}, x[DIV_WLEN-1:0]} : x;
    endfunction

    div_operand_prep #(.XLEN(XLEN)) u_prep (
        .div_signed(div_signed),
        .divw      (divw),
        .div_op1   (div_op1),
        .div_op2   (div_op2),
        .a_ext     (a_ext),
        .a_abs     (a_abs),
        .b_abs     (b_abs),
        .div_zero  (div_zero),
        .ovf       (ovf),
        .q_neg     (q_neg),
        .r_neg     (r_neg)
    );

    // dvd shifts out dividend bits from the top while quotient bits fill in from the bottom
    always_comb begin
        shifted = {rem, dvd[XLEN-1]};
        ge = shifted >= {1'b0, dsr};
        nxt_rem = XLEN'(ge ? shifted - {1'b0, dsr} : shifted);
        nxt_dvd = {dvd[XLEN-2:0], ge};
        fix_q = wfix(w_r, q_neg_r ? -nxt_dvd : nxt_dvd);
        fix_r = wfix(w_r, r_neg_r ? -nxt_rem : nxt_rem);
        spec_q = wfix(divw, div_zero ? '1 : a_ext);
        spec_r = wfix(divw, div_zero ? a_ext : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
            quotient <= '0;
            remainder <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                state <= IDLE;
                div_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (div_valid) begin
                        dvd <= divw ? {a_abs[DIV_WLEN-1:0], {(XLEN-DIV_WLEN){1'b0}}} : a_abs;
                        rem <= '0;
                        dsr <= b_abs;
                        cnt <= divw ? ITER_W : ITER_X;
                        q_neg_r <= q_neg;
                        r_neg_r <= r_neg;
                        w_r <= divw;
                        div_ready <= 1'b0;
                        if (div_zero | ovf) begin
                            state <= DONE;
                            out_valid <= 1'b1;
                            quotient <= spec_q;
                            remainder <= spec_r;
                        end else begin
                            state <= BUSY;
                        end
                    end
                    BUSY: begin
                        rem <= nxt_rem;
                        dvd <= nxt_dvd;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            out_valid <= 1'b1;
                            quotient <= fix_q;
                            remainder <= fix_r;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        div_ready <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iter_div_responder.sv
// tb_iter_div_responder: directed and randomized checks of the divider against an arithmetic reference
module tb_iter_div_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_valid = 1'b0;
    logic        flush = 1'b0;
    logic        div_signed = 1'b0;
    logic        divw = 1'b0;
    logic [63:0] div_op1 = '0;
    logic [63:0] div_op2 = '0;
    logic        div_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sg;
        logic        w;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    iter_div_responder dut (
        .clk       (clk),
        .rst       (rst),
        .div_valid (div_valid),
        .flush     (flush),
        .div_signed(div_signed),
        .divw      (divw),
        .div_op1   (div_op1),
        .div_op2   (div_op2),
        .div_ready (div_ready),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sg, input logic w,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        lat = w ? 33 : 65;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin
                q32 = '1; r32 = a32; lat = 1;
            end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; lat = 1;
            end else if (sg) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else if (b == 0) begin
            q = '1; r = a; lat = 1;
        end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = '0; lat = 1;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // leaves the bench at the negedge of cycle 1, with operands scrambled after capture
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sg, input logic w);
        @(negedge clk);
        div_op1 = a; div_op2 = b; div_signed = sg; divw = w; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        div_op1 = {$urandom, $urandom};
        div_op2 = {$urandom, $urandom};
        div_signed = 1'($urandom);
        divw = 1'($urandom);
    endtask

    task automatic wait_result(input int start, output int cyc);
        cyc = start;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", div_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (quotient !== 64'd0) begin errors++; $display("FAIL reset_q: got %h expected 0", quotient); end
        if (remainder !== 64'd0) begin errors++; $display("FAIL reset_r: got %h expected 0", remainder); end
    endtask

    task automatic test_basic;
        int cyc, bad;
        issue(64'd100, 64'd7, 1'b0, 1'b0);
        cyc = 1;
        bad = 0;
        while (!out_valid && cyc < 200) begin
            if (div_ready !== 1'b0) bad++;
            if (cyc == 5) begin
                div_valid = 1'b1; div_op1 = 64'd999; div_op2 = 64'd3; div_signed = 1'b0; divw = 1'b0;
            end else begin
                div_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        checks += 5;
        if (cyc !== 65) begin errors++; $display("FAIL basic_lat: got %0d expected 65", cyc); end
        if (quotient !== 64'd14) begin errors++; $display("FAIL basic_q: got %h expected %h", quotient, 64'd14); end
        if (remainder !== 64'd2) begin errors++; $display("FAIL basic_r: got %h expected %h", remainder, 64'd2); end
        if (bad !== 0) begin errors++; $display("FAIL basic_busy_ready: got %0d ready cycles expected 0", bad); end
        if (div_ready !== 1'b0) begin errors++; $display("FAIL basic_done_ready: got %b expected 0", div_ready); end
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_strobe: got %b expected 0", out_valid); end
        if (div_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %b expected 1", div_ready); end
        if (quotient !== 64'd14) begin errors++; $display("FAIL basic_hold_q: got %h expected %h", quotient, 64'd14); end
    endtask

    task automatic test_directed;
        vec_t vecs[$];
        int cyc;
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65});
        vecs.push_back('{64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1});
        vecs.push_back('{64'hDEAD_BEEF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33});
        vecs.push_back('{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1});
        vecs.push_back('{64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        vecs.push_back('{64'h0000_0000_0000_0064, 64'h0000_0000_0000_0007, 1'b0, 1'b1, 64'd14, 64'd2, 33});
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].w);
            wait_result(1, cyc);
            checks += 3;
            if (cyc !== vecs[i].lat) begin errors++; $display("FAIL dir%0d_lat: got %0d expected %0d", i, cyc, vecs[i].lat); end
            if (quotient !== vecs[i].q) begin errors++; $display("FAIL dir%0d_q: got %h expected %h", i, quotient, vecs[i].q); end
            if (remainder !== vecs[i].r) begin errors++; $display("FAIL dir%0d_r: got %h expected %h", i, remainder, vecs[i].r); end
        end
    endtask

    task automatic test_flush;
        int cyc, seen;
        issue(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks += 2;
        if (div_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", div_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_dropped: got %0d strobes expected 0", seen); end
        issue(64'd100, 64'd7, 1'b0, 1'b0);
        wait_result(1, cyc);
        checks += 3;
        if (cyc !== 65) begin errors++; $display("FAIL flush_next_lat: got %0d expected 65", cyc); end
        if (quotient !== 64'd14) begin errors++; $display("FAIL flush_next_q: got %h expected %h", quotient, 64'd14); end
        if (remainder !== 64'd2) begin errors++; $display("FAIL flush_next_r: got %h expected %h", remainder, 64'd2); end
    endtask

    task automatic test_reset_busy;
        int seen;
        issue(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (div_ready !== 1'b1) begin errors++; $display("FAIL rstbusy_ready: got %b expected 1", div_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstbusy_valid: got %b expected 0", out_valid); end
        if (quotient !== 64'd0) begin errors++; $display("FAIL rstbusy_q: got %h expected 0", quotient); end
        if (remainder !== 64'd0) begin errors++; $display("FAIL rstbusy_r: got %h expected 0", remainder); end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rstbusy_dropped: got %0d strobes expected 0", seen); end
    endtask

    task automatic test_flush_valid;
        int seen;
        @(negedge clk);
        flush = 1'b1; div_valid = 1'b1; div_op1 = 64'd100; div_op2 = 64'd7; div_signed = 1'b0; divw = 1'b0;
        @(negedge clk);
        flush = 1'b0; div_valid = 1'b0;
        checks++;
        if (div_ready !== 1'b1) begin errors++; $display("FAIL flushvalid_ready: got %b expected 1", div_ready); end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flushvalid_accept: got %0d strobes expected 0", seen); end
        issue(64'd55, 64'd0, 1'b0, 1'b0);
        flush = 1'b1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flushdone_valid: got %b expected 1", out_valid); end
        @(negedge clk);
        flush = 1'b0;
        checks += 3;
        if (div_ready !== 1'b1) begin errors++; $display("FAIL flushdone_ready: got %b expected 1", div_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flushdone_strobe: got %b expected 0", out_valid); end
        if (remainder !== 64'd55) begin errors++; $display("FAIL flushdone_r: got %h expected %h", remainder, 64'd55); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        div_op1 = 64'd5; div_op2 = 64'd0; div_signed = 1'b0; divw = 1'b0; div_valid = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %b expected 1", out_valid); end
        if (remainder !== 64'd5) begin errors++; $display("FAIL b2b_first_r: got %h expected %h", remainder, 64'd5); end
        div_op1 = 64'd100; div_op2 = 64'd7;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid: got %b expected 0", out_valid); end
        if (div_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 1", div_ready); end
        if (quotient !== '1) begin errors++; $display("FAIL b2b_hold_q: got %h expected all ones", quotient); end
        @(negedge clk);
        div_valid = 1'b0;
        wait_result(3, cyc);
        checks += 3;
        if (cyc !== 67) begin errors++; $display("FAIL b2b_second_lat: got %0d expected 67", cyc); end
        if (quotient !== 64'd14) begin errors++; $display("FAIL b2b_second_q: got %h expected %h", quotient, 64'd14); end
        if (remainder !== 64'd2) begin errors++; $display("FAIL b2b_second_r: got %h expected %h", remainder, 64'd2); end
    endtask

    task automatic test_random;
        logic [63:0] a, b, q, r;
        logic sg, w;
        int lat, cyc, ma, mb;
        for (int i = 0; i < 40; i++) begin
            ma = int'($urandom_range(0, 4));
            mb = int'($urandom_range(0, 6));
            a = ma == 0 ? 64'h8000_0000_0000_0000 : ma == 1 ? {$urandom, 32'h8000_0000} : {$urandom, $urandom};
            b = mb == 0 ? 64'd0 : mb == 1 ? '1 : mb == 2 ? 64'($urandom_range(1, 20)) : {$urandom, $urandom};
            if (mb == 2 && $urandom_range(0, 1) == 1) b = -b;
            if (mb == 3) b = {32'($urandom), 32'd0};
            if (mb == 4) b = 64'($urandom);
            sg = 1'($urandom);
            w = 1'($urandom);
            model(a, b, sg, w, q, r, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b, sg, w);
            wait_result(1, cyc);
            checks += 3;
            if (cyc !== lat) begin errors++; $display("FAIL rand%0d_lat: got %0d expected %0d", i, cyc, lat); end
            if (quotient !== q) begin errors++; $display("FAIL rand%0d_q: a=%h b=%h s=%b w=%b got %h expected %h", i, a, b, sg, w, quotient, q); end
            if (remainder !== r) begin errors++; $display("FAIL rand%0d_r: a=%h b=%h s=%b w=%b got %h expected %h", i, a, b, sg, w, remainder, r); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_flush();
        test_reset_busy();
        test_flush_valid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
